// File: rtl/mips_exec_unit.sv
// Execution stage of the single-cycle MIPS core: ALU-control decode, 32-bit ALU,
// PC-increment and branch-target adders, with results captured one clock after operands.
module mips_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [15:0]      imm,
  input  logic             halt,
  input  logic             branch,
  output logic [2:0]       operation,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_next
);

  typedef enum logic [2:0] {
    OpAnd = 3'b000,
    OpOr  = 3'b001,
    OpAdd = 3'b010,
    OpSll = 3'b011,
    OpSrl = 3'b100,
    OpNop = 3'b101,
    OpSub = 3'b110,
    OpSlt = 3'b111
  } alu_sel_e;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;
  localparam logic [5:0] FunctSll = 6'b000000;
  localparam logic [5:0] FunctSrl = 6'b000010;

  alu_sel_e         alu_sel;
  logic [WIDTH-1:0] alu_d;
  logic             zero_d;
  logic [WIDTH-1:0] pc_incr;
  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] pc_next_d;

  logic [WIDTH-1:0] alu_result_q;
  logic             zero_q;
  logic [WIDTH-1:0] pc_next_q;

  // ALU-control decode; unknown R-type functs fall back to ADD
  always_comb begin
    alu_sel = OpAdd;
    unique case (alu_op)
      2'b00: alu_sel = OpAdd;
      2'b01: alu_sel = OpSub;
      2'b11: alu_sel = OpOr;
      2'b10: begin
        case (funct)
          FunctAdd: alu_sel = OpAdd;
          FunctSub: alu_sel = OpSub;
          FunctAnd: alu_sel = OpAnd;
          FunctOr:  alu_sel = OpOr;
          FunctSlt: alu_sel = OpSlt;
          FunctSll: alu_sel = OpSll;
          FunctSrl: alu_sel = OpSrl;
          default:  alu_sel = OpAdd;
        endcase
      end
      default: alu_sel = OpAdd;
    endcase
  end

  assign operation = alu_sel;

  always_comb begin
    alu_d = '0;
    unique case (alu_sel)
      OpAnd: alu_d = a & b;
      OpOr:  alu_d = a | b;
      OpAdd: alu_d = a + b;
      OpSub: alu_d = a - b;
      OpSlt: alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSll: alu_d = b << shamt;
      OpSrl: alu_d = b >> shamt;
      OpNop: alu_d = '0;
      default: alu_d = '0;
    endcase
  end

  assign zero_d = (alu_d == '0);

  assign pc_incr   = pc + (halt ? WIDTH'(0) : WIDTH'(4));
  assign br_offset = {{(WIDTH-16){imm[15]}}, imm} << 2;
  assign br_target = pc_incr + br_offset;
  assign pc_next_d = (branch && zero_d) ? br_target : pc_incr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      pc_next_q    <= '0;
    end else begin
      alu_result_q <= alu_d;
      zero_q       <= zero_d;
      pc_next_q    <= pc_next_d;
    end
  end

  assign alu_result = alu_result_q;
  assign zero       = zero_q;
  assign pc_next    = pc_next_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: directed cases plus randomized vectors
// compared against a behavioural model of the execution stage.
module tb_mips_exec_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [15:0] imm;
  logic        halt;
  logic        branch;
  logic [2:0]  operation;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc_next;

  int vectors;
  int miscompares;

  logic [5:0] funct_list [7];

  mips_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_op     (alu_op),
    .funct      (funct),
    .shamt      (shamt),
    .a          (a),
    .b          (b),
    .pc         (pc),
    .imm        (imm),
    .halt       (halt),
    .branch     (branch),
    .operation  (operation),
    .alu_result (alu_result),
    .zero       (zero),
    .pc_next    (pc_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: operation code from the decode table
  function automatic logic [2:0] ref_op(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b11) return 3'b001;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b000000: return 3'b011;
      6'b000010: return 3'b100;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] sh);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return 32'((longint'(x) + longint'(y)) % 64'h1_0000_0000);
      3'b110: return 32'((longint'(x) - longint'(y) + 64'h1_0000_0000) % 64'h1_0000_0000);
      3'b111: return (sx < sy) ? 32'd1 : 32'd0;
      3'b011: return 32'((longint'(y) * (64'd1 << sh)) % 64'h1_0000_0000);
      3'b100: return 32'(longint'(y) / (64'd1 << sh));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_pc(input logic [31:0] p, input logic h,
                                         input logic [15:0] im, input logic br,
                                         input logic z);
    longint incr;
    longint tgt;
    incr = (longint'(p) + (h ? 0 : 4)) % 64'h1_0000_0000;
    tgt  = (incr + longint'($signed(im)) * 4 + 64'h1_0000_0000) % 64'h1_0000_0000;
    return (br && z) ? 32'(tgt) : 32'(incr);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one set of operands, check decode now and registered outputs after the edge
  task automatic step(input string tag, input logic [1:0] op, input logic [5:0] fn,
                      input logic [4:0] sh, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] p, input logic [15:0] im, input logic h,
                      input logic br);
    logic [2:0]  e_op;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_pc;
    alu_op = op; funct = fn; shamt = sh; a = x; b = y;
    pc = p; imm = im; halt = h; branch = br;
    e_op   = ref_op(op, fn);
    e_res  = ref_alu(e_op, x, y, sh);
    e_zero = (e_res == 32'd0);
    e_pc   = ref_pc(p, h, im, br, e_zero);
    #1;
    check({tag, ".operation"}, {29'd0, operation}, {29'd0, e_op});
    @(posedge clk);
    #1;
    check({tag, ".alu_result"}, alu_result, e_res);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
    check({tag, ".pc_next"}, pc_next, e_pc);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".alu_result"}, alu_result, 32'd0);
    check({tag, ".zero"}, {31'd0, zero}, 32'd0);
    check({tag, ".pc_next"}, pc_next, 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    funct_list[0] = 6'b100000; funct_list[1] = 6'b100010; funct_list[2] = 6'b100100;
    funct_list[3] = 6'b100101; funct_list[4] = 6'b101010; funct_list[5] = 6'b000000;
    funct_list[6] = 6'b000010;

    // Reset held with arbitrary inputs
    reset = 1'b1;
    alu_op = 2'b00; funct = 6'h2a; shamt = 5'd3; a = 32'h1234_5678; b = 32'h0000_0001;
    pc = 32'h0000_1000; imm = 16'h0010; halt = 1'b0; branch = 1'b1;
    #1;
    check_cleared("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_held");
    reset = 1'b0;

    // R-type decode with a=7, b=5
    step("rt_add", 2'b10, 6'b100000, 5'd0, 32'd7, 32'd5, 32'h0, 16'h0, 1'b0, 1'b0);
    check("rt_add.const", alu_result, 32'd12);
    step("rt_sub", 2'b10, 6'b100010, 5'd0, 32'd7, 32'd5, 32'h4, 16'h0, 1'b0, 1'b0);
    check("rt_sub.const", alu_result, 32'd2);
    step("rt_and", 2'b10, 6'b100100, 5'd0, 32'd7, 32'd5, 32'h8, 16'h0, 1'b0, 1'b0);
    check("rt_and.const", alu_result, 32'd5);
    step("rt_or", 2'b10, 6'b100101, 5'd0, 32'd7, 32'd5, 32'hc, 16'h0, 1'b0, 1'b0);
    check("rt_or.const", alu_result, 32'd7);
    step("rt_slt0", 2'b10, 6'b101010, 5'd0, 32'd7, 32'd5, 32'h10, 16'h0, 1'b0, 1'b0);
    check("rt_slt0.const", alu_result, 32'd0);
    step("rt_slt1", 2'b10, 6'b101010, 5'd0, 32'hffff_ffff, 32'd5, 32'h14, 16'h0, 1'b0, 1'b0);
    check("rt_slt1.const", alu_result, 32'd1);
    step("slt_min", 2'b10, 6'b101010, 5'd0, 32'h8000_0000, 32'd0, 32'h18, 16'h0, 1'b0, 1'b0);
    check("slt_min.const", alu_result, 32'd1);
    step("rt_other", 2'b10, 6'b111111, 5'd0, 32'd7, 32'd5, 32'h1c, 16'h0, 1'b0, 1'b0);
    check("rt_other.op", {29'd0, operation}, 32'd2);

    // Shifts
    step("sll4", 2'b10, 6'b000000, 5'd4, 32'd0, 32'h8000_0001, 32'h20, 16'h0, 1'b0, 1'b0);
    check("sll4.const", alu_result, 32'h0000_0010);
    step("srl31", 2'b10, 6'b000010, 5'd31, 32'd0, 32'h8000_0001, 32'h24, 16'h0, 1'b0, 1'b0);
    check("srl31.const", alu_result, 32'h0000_0001);
    step("sll0", 2'b10, 6'b000000, 5'd0, 32'd0, 32'h8000_0001, 32'h28, 16'h0, 1'b0, 1'b0);
    check("sll0.const", alu_result, 32'h8000_0001);
    step("srl0", 2'b10, 6'b000010, 5'd0, 32'd0, 32'h8000_0001, 32'h2c, 16'h0, 1'b0, 1'b0);
    check("srl0.const", alu_result, 32'h8000_0001);

    // Branch taken (backward) and not taken
    step("br_taken", 2'b01, 6'h0, 5'd0, 32'd9, 32'd9, 32'h100, 16'hffff, 1'b0, 1'b1);
    check("br_taken.const", pc_next, 32'h100);
    check("br_taken.zero", {31'd0, zero}, 32'd1);
    step("br_not", 2'b01, 6'h0, 5'd0, 32'd9, 32'd8, 32'h100, 16'hffff, 1'b0, 1'b1);
    check("br_not.const", pc_next, 32'h104);
    check("br_not.zero", {31'd0, zero}, 32'd0);

    // Halt and PC wrap
    step("halt", 2'b00, 6'h0, 5'd0, 32'd1, 32'd2, 32'h40, 16'h0, 1'b1, 1'b0);
    check("halt.const", pc_next, 32'h40);
    step("wrap", 2'b00, 6'h0, 5'd0, 32'd1, 32'd2, 32'hffff_fffc, 16'h0, 1'b0, 1'b0);
    check("wrap.const", pc_next, 32'h0);

    // Add overflow wraps silently
    step("ovf", 2'b00, 6'h0, 5'd0, 32'h7fff_ffff, 32'd1, 32'h200, 16'h0, 1'b0, 1'b0);
    check("ovf.const", alu_result, 32'h8000_0000);
    step("add_zero", 2'b00, 6'h0, 5'd0, 32'd1, 32'hffff_ffff, 32'h204, 16'h0, 1'b0, 1'b0);
    check("add_zero.const", {31'd0, zero}, 32'd1);
    step("ori", 2'b11, 6'h0, 5'd0, 32'h0f0f_0000, 32'h0000_00f0, 32'h208, 16'h0, 1'b0, 1'b0);

    // Reset mid-stream clears outputs immediately, then pipeline resumes
    #2;
    reset = 1'b1;
    #1;
    check_cleared("reset_mid");
    @(posedge clk);
    #1;
    check_cleared("reset_mid_held");
    reset = 1'b0;
    step("resume", 2'b10, 6'b100000, 5'd0, 32'd40, 32'd2, 32'h300, 16'h0, 1'b0, 1'b0);
    check("resume.const", alu_result, 32'd42);

    // Randomized vectors against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  r_op;
      logic [5:0]  r_fn;
      logic [31:0] r_a;
      logic [31:0] r_b;
      r_op = 2'($urandom_range(0, 3));
      r_fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_list[$urandom_range(0, 6)];
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
      step("rand", r_op, r_fn, 5'($urandom), r_a, r_b, {$urandom} & 32'hffff_fffc,
           16'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
Name: mips_exec_unit

Overview:
- Execution-stage block for the single-cycle MIPS core.
- Integrates three functions:
  - ALU-control decode (ALUOp/funct to 3-bit Operation).
  - 32-bit ALU with zero flag.
  - Two 32-bit adders: PC increment and branch target.
- Combinational results are captured in an output register, so a result appears one clock after its operands.
- Sits between the register file/immediate path and the writeback/PC-update logic.

Parameters:
- WIDTH, 32, datapath width; only 32 is required to work.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all registered outputs.
- alu_op  input  2  ALUOp from main control.
- funct  input  6  instr[5:0].
- shamt  input  5  instr[10:6].
- a  input  32  ALU operand A (rs data).
- b  input  32  ALU operand B (rt data or sign-extended immediate).
- pc  input  32  current PC.
- imm  input  16  instr[15:0].
- halt  input  1  when 1, PC increment is 0 instead of 4.
- branch  input  1  branch instruction flag.
- operation  output  3  decoded ALU operation (combinational).
- alu_result  output  32  registered ALU result.
- zero  output  1  registered (ALU result == 0).
- pc_next  output  32  registered next PC.

Behaviour:
- Reset: asynchronous, active-high. While reset is high, alu_result=0, zero=0, pc_next=0 regardless of clk. The first capture happens on the first rising clk after reset deasserts.
- ALU-control decode (combinational, no latency):
  - alu_op=00 -> 010 (ADD).
  - alu_op=01 -> 110 (SUB).
  - alu_op=11 -> 001 (OR).
  - alu_op=10 decodes funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - 000000 -> 011 (sll)
    - 000010 -> 100 (srl)
    - any other funct -> 010 (ADD).
- ALU (combinational):
  - 000: a & b
  - 001: a | b
  - 010: a + b, modulo 2^32, carry/overflow discarded, no trap
  - 110: a - b, modulo 2^32
  - 111: signed compare, 1 if $signed(a) < $signed(b) else 0, zero-extended to 32 bits
  - 011: b << shamt
  - 100: b >> shamt, logical
  - 101: result 0
  - Zero flag = (ALU result == 32'h0).
- Adders (combinational):
  - pc_incr = pc + (halt ? 0 : 4).
  - br_target = pc_incr + ({{16{imm[15]}}, imm} << 2).
  - Both wrap modulo 2^32.
- Next PC: pc_next_d = (branch & zero_d) ? br_target : pc_incr, where zero_d is the combinational zero flag.
- On each rising clk (reset low): alu_result<=ALU result, zero<=zero_d, pc_next<=pc_next_d. Latency is 1 cycle; there is no handshake.
- Boundary conditions:
  - Shift by 0 returns b.
  - Shift by 31 is legal.
  - SLT with a=0x80000000, b=0 yields 1.
  - PC wrap: pc=0xFFFFFFFC, halt=0 gives pc_incr=0.
  - Negative imm gives a backward branch.
  - Reset asserted mid-stream clears outputs immediately; the pipeline resumes normally after release.

Test Plan:
- Reset: hold reset=1 with arbitrary inputs -> alu_result=0, zero=0, pc_next=0. After release, first clk edge captures the current inputs.
- R-type decode: alu_op=10, a=7, b=5, sweep funct. One clk later:
  - 100000 -> 12
  - 100010 -> 2
  - 100100 -> 5
  - 100101 -> 7
  - 101010 -> 0
  - a=-1 (0xFFFFFFFF), funct=101010 -> 1
  - Also check operation bits for each funct.
- Shifts: alu_op=10, b=0x80000001:
  - funct=000000, shamt=4 -> 0x00000010
  - funct=000010, shamt=31 -> 0x00000001
  - shamt=0 -> b unchanged
- Branch taken/not taken: alu_op=01, pc=0x100, imm=0xFFFF, branch=1.
  - a=b=9 -> zero=1, pc_next=0x100.
  - a=9, b=8 -> zero=0, pc_next=0x104.
- Halt and wrap:
  - halt=1, pc=0x40, branch=0 -> pc_next=0x40.
  - halt=0, pc=0xFFFFFFFC -> pc_next=0.
- Load/store add and overflow: alu_op=00.
  - a=0x7FFFFFFF, b=1 -> alu_result=0x80000000, zero=0.
  - a=1, b=0xFFFFFFFF -> alu_result=0, zero=1.
